// File: rtl/huff_merge_sched.sv
//------------------------------------------------------------------------------
// Module   : huff_merge_sched
// Brief    : Huffman tree merge scheduler with bubble-sort node store and
//            one merge record per sort/merge round.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module huff_merge_sched #(
    parameter int         MAX_LEAVES  = 4,
    parameter logic [3:0] PARENT_BASE = 4'h8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_node,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_left,
    output logic [3:0] out_right,
    output logic [3:0] out_parent,
    output logic [3:0] out_freq,
    output logic       busy,
    output logic       done,
    output logic [3:0] root_id,
    output logic       sat
);

    localparam int CW = $clog2(MAX_LEAVES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SORT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     nodes_q [MAX_LEAVES];
    logic [7:0]     nodes_d [MAX_LEAVES];
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           swapped_q, swapped_d;
    logic [3:0]     parent_q, parent_d;
    logic           busy_q, busy_d;
    logic           sat_q, sat_d;
    logic [3:0]     root_q, root_d;

    logic           accept;
    logic [7:0]     cmp_a, cmp_b;
    logic           do_swap;
    logic [4:0]     sum5;
    logic [3:0]     freq_sat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < MAX_LEAVES; i++) begin
                nodes_q[i] <= 8'h00;
            end
            count_q   <= '0;
            idx_q     <= '0;
            swapped_q <= 1'b0;
            parent_q  <= PARENT_BASE;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
            root_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            nodes_q   <= nodes_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            swapped_q <= swapped_d;
            parent_q  <= parent_d;
            busy_q    <= busy_d;
            sat_q     <= sat_d;
            root_q    <= root_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nodes_d   = nodes_q;
        count_d   = count_q;
        idx_d     = idx_q;
        swapped_d = swapped_q;
        parent_d  = parent_q;
        busy_d    = busy_q;
        sat_d     = sat_q;
        root_d    = root_q;

        in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
        accept   = in_valid && in_ready;

        // Adjacent pair currently under the sort cursor
        cmp_a = nodes_q[0];
        cmp_b = nodes_q[0];
        for (int i = 0; i < MAX_LEAVES - 1; i++) begin
            if (idx_q == CW'(i)) begin
                cmp_a = nodes_q[i];
                cmp_b = nodes_q[i + 1];
            end
        end
        do_swap = (cmp_a[7:4] > cmp_b[7:4]);

        sum5     = {1'b0, nodes_q[0][7:4]} + {1'b0, nodes_q[1][7:4]};
        freq_sat = sum5[4] ? 4'hF : sum5[3:0];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    nodes_d[0] = in_node;
                    count_d    = CW'(1);
                    busy_d     = 1'b1;
                    sat_d      = 1'b0;
                    parent_d   = PARENT_BASE;
                    idx_d      = '0;
                    swapped_d  = 1'b0;
                    state_d    = (in_last || (MAX_LEAVES == 1)) ? S_SORT : S_LOAD;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    for (int i = 0; i < MAX_LEAVES; i++) begin
                        if (count_q == CW'(i)) begin
                            nodes_d[i] = in_node;
                        end
                    end
                    count_d   = count_q + CW'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    if (in_last || (count_q == CW'(MAX_LEAVES - 1))) begin
                        state_d = S_SORT;
                    end
                end
            end

            S_SORT: begin
                if (count_q < CW'(2)) begin
                    state_d = S_DONE;
                    root_d  = nodes_q[0][3:0];
                    busy_d  = 1'b0;
                end else begin
                    for (int i = 0; i < MAX_LEAVES - 1; i++) begin
                        if ((idx_q == CW'(i)) && do_swap) begin
                            nodes_d[i]     = cmp_b;
                            nodes_d[i + 1] = cmp_a;
                        end
                    end
                    // A clean sweep means the store is ordered
                    if (idx_q == count_q - CW'(2)) begin
                        idx_d     = '0;
                        swapped_d = 1'b0;
                        if (!(swapped_q || do_swap)) begin
                            state_d = S_EMIT;
                        end
                    end else begin
                        idx_d     = idx_q + CW'(1);
                        swapped_d = swapped_q || do_swap;
                    end
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    for (int i = 0; i < MAX_LEAVES - 2; i++) begin
                        nodes_d[i] = nodes_q[i + 2];
                    end
                    for (int i = 0; i < MAX_LEAVES; i++) begin
                        if (count_q - CW'(2) == CW'(i)) begin
                            nodes_d[i] = {freq_sat, parent_q};
                        end
                    end
                    count_d   = count_q - CW'(1);
                    parent_d  = parent_q + 4'h1;
                    sat_d     = sat_q || sum5[4];
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    state_d   = S_SORT;
                end
            end

            S_DONE: begin
                count_d = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid  = (state_q == S_EMIT);
    assign out_left   = out_valid ? nodes_q[0][3:0] : 4'h0;
    assign out_right  = out_valid ? nodes_q[1][3:0] : 4'h0;
    assign out_parent = out_valid ? parent_q        : 4'h0;
    assign out_freq   = out_valid ? freq_sat        : 4'h0;
    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign root_id    = root_q;
    assign sat        = sat_q;

endmodule

`default_nettype wire
